// File: rtl/vec_mul_pipe.sv
// vec_mul_pipe: LANES independent WIDTHxWIDTH integer multipliers behind a STAGES-deep pipe with one global advance.
// Optional per-lane accumulate is compiled in by defining VEC_MUL_MAC_EN.
module vec_mul_pipe #(
    parameter int WIDTH  = 8,
    parameter int LANES  = 4,
    parameter int STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   in_a,
    input  logic [LANES*WIDTH-1:0]   in_b,
    input  logic                     in_signed,
`ifdef VEC_MUL_MAC_EN
    input  logic                     in_acc,
    input  logic                     in_acc_clr,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*2*WIDTH-1:0] out_prod
);
    localparam int PW = 2 * WIDTH;
    localparam int H  = WIDTH / 2;
    localparam int MW = WIDTH - 1 - H;

    function automatic logic signed [PW-1:0] ext_a(input logic [WIDTH-1:0] a, input logic sgn);
        logic signed [WIDTH:0] t;
        t     = $signed({sgn & a[WIDTH-1], a});
        ext_a = PW'(t);
    endfunction

    function automatic logic signed [PW-1:0] row_lo(input logic signed [PW-1:0] ax,
                                                    input logic [H-1:0] bl);
        row_lo = ax * $signed(PW'(bl));
    endfunction

    function automatic logic signed [PW-1:0] row_mid(input logic signed [PW-1:0] ax,
                                                     input logic [MW-1:0] bm);
        row_mid = (ax * $signed(PW'(bm))) <<< H;
    endfunction

    function automatic logic signed [PW-1:0] row_top(input logic signed [PW-1:0] ax,
                                                     input logic bt);
        row_top = bt ? (ax <<< (WIDTH - 1)) : '0;
    endfunction

    // The b-MSB row weighs -2^(WIDTH-1) for signed beats and +2^(WIDTH-1) for unsigned ones.
    function automatic logic signed [PW-1:0] combine(input logic signed [PW-1:0] lo,
                                                     input logic signed [PW-1:0] mid,
                                                     input logic signed [PW-1:0] top,
                                                     input logic sgn);
        combine = sgn ? (lo + mid - top) : (lo + mid + top);
    endfunction

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic [LANES*PW-1:0] lo_c, mid_c, top_c;

    always_comb begin
        lo_c  = '0;
        mid_c = '0;
        top_c = '0;
        for (int i = 0; i < LANES; i++) begin
            lo_c[i*PW +: PW]  = row_lo(ext_a(in_a[i*WIDTH +: WIDTH], in_signed),
                                       in_b[i*WIDTH +: H]);
            mid_c[i*PW +: PW] = row_mid(ext_a(in_a[i*WIDTH +: WIDTH], in_signed),
                                        in_b[i*WIDTH + H +: MW]);
            top_c[i*PW +: PW] = row_top(ext_a(in_a[i*WIDTH +: WIDTH], in_signed),
                                        in_b[i*WIDTH + WIDTH - 1]);
        end
    end

    logic                fin_vld;
    logic                fin_sgn;
    logic [LANES*PW-1:0] fin_lo, fin_mid, fin_top;
`ifdef VEC_MUL_MAC_EN
    logic                fin_acc;
    logic                fin_clr;
`endif

    generate
        if (STAGES == 1) begin : g_direct
            assign fin_vld = in_valid;
            assign fin_sgn = in_signed;
            assign fin_lo  = lo_c;
            assign fin_mid = mid_c;
            assign fin_top = top_c;
`ifdef VEC_MUL_MAC_EN
            assign fin_acc = in_acc;
            assign fin_clr = in_acc_clr;
`endif
        end else begin : g_pipe
            localparam int D = STAGES - 1;

            logic                vld_p [D];
            logic                sgn_p [D];
            logic [LANES*PW-1:0] lo_p  [D];
            logic [LANES*PW-1:0] mid_p [D];
            logic [LANES*PW-1:0] top_p [D];
`ifdef VEC_MUL_MAC_EN
            logic                acc_p [D];
            logic                clr_p [D];
`endif

            // Stage p0: partial-product rows; later pN stages carry them until the final sum.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < D; k++) vld_p[k] <= 1'b0;
                end else if (adv) begin
                    vld_p[0] <= in_valid;
                    for (int k = 1; k < D; k++) vld_p[k] <= vld_p[k-1];
                end
            end

            always_ff @(posedge clk) begin
                if (adv) begin
                    sgn_p[0] <= in_signed;
                    lo_p[0]  <= lo_c;
                    mid_p[0] <= mid_c;
                    top_p[0] <= top_c;
`ifdef VEC_MUL_MAC_EN
                    acc_p[0] <= in_acc;
                    clr_p[0] <= in_acc_clr;
`endif
                    for (int k = 1; k < D; k++) begin
                        sgn_p[k] <= sgn_p[k-1];
                        lo_p[k]  <= lo_p[k-1];
                        mid_p[k] <= mid_p[k-1];
                        top_p[k] <= top_p[k-1];
`ifdef VEC_MUL_MAC_EN
                        acc_p[k] <= acc_p[k-1];
                        clr_p[k] <= clr_p[k-1];
`endif
                    end
                end
            end

            assign fin_vld = vld_p[D-1];
            assign fin_sgn = sgn_p[D-1];
            assign fin_lo  = lo_p[D-1];
            assign fin_mid = mid_p[D-1];
            assign fin_top = top_p[D-1];
`ifdef VEC_MUL_MAC_EN
            assign fin_acc = acc_p[D-1];
            assign fin_clr = clr_p[D-1];
`endif
        end
    endgenerate

    logic [LANES*PW-1:0] prod_c, load_c;

    always_comb begin
        prod_c = '0;
        for (int i = 0; i < LANES; i++) begin
            prod_c[i*PW +: PW] = combine(fin_lo[i*PW +: PW], fin_mid[i*PW +: PW],
                                         fin_top[i*PW +: PW], fin_sgn);
        end
    end

`ifdef VEC_MUL_MAC_EN
    logic [LANES*PW-1:0] acc_q;

    always_comb begin
        load_c = prod_c;
        if (fin_acc && !fin_clr) begin
            for (int i = 0; i < LANES; i++) begin
                load_c[i*PW +: PW] = prod_c[i*PW +: PW] + acc_q[i*PW +: PW];
            end
        end
    end

    // Updated only when a beat actually enters the result stage, so a stall cannot re-accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (adv && fin_vld && (fin_acc || fin_clr)) begin
            acc_q <= load_c;
        end
    end
`else
    assign load_c = prod_c;
`endif

    // Result stage: last register of the pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_prod  <= '0;
        end else if (adv) begin
            out_valid <= fin_vld;
            if (fin_vld) out_prod <= load_c;
        end
    end

endmodule

// File: tb/tb_vec_mul_pipe.sv
// tb_vec_mul_pipe: directed and random stimulus for vec_mul_pipe (WIDTH=8, LANES=4, STAGES=2),
// scoreboarded against integer lane products; MAC section built when VEC_MUL_MAC_EN is defined.
`timescale 1ns/1ps
module tb_vec_mul_pipe;
    localparam int WIDTH  = 8;
    localparam int LANES  = 4;
    localparam int STAGES = 2;
    localparam int PW     = 2 * WIDTH;
    localparam int AW     = LANES * WIDTH;
    localparam int OW     = LANES * PW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_a;
    logic [AW-1:0] in_b;
    logic          in_signed;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_prod;
`ifdef VEC_MUL_MAC_EN
    logic          in_acc;
    logic          in_acc_clr;
    logic [PW-1:0] m_acc [LANES];
`endif

    int            checks   = 0;
    int            failures = 0;
    int            n_out    = 0;
    logic [OW-1:0] exp_q [$];
    logic [OW-1:0] got_q [$];
    logic          prev_stall = 1'b0;
    logic [OW-1:0] prev_prod  = '0;
    logic          last_acc   = 1'b0;

    vec_mul_pipe #(.WIDTH(WIDTH), .LANES(LANES), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
`ifdef VEC_MUL_MAC_EN
        .in_acc    (in_acc),
        .in_acc_clr(in_acc_clr),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [OW-1:0] ref_mul(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                              input logic sgn);
        logic [OW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            logic [WIDTH-1:0] ai, bi;
            longint x, y, p;
            ai = a[i*WIDTH +: WIDTH];
            bi = b[i*WIDTH +: WIDTH];
            x  = sgn ? longint'($signed(ai)) : longint'(ai);
            y  = sgn ? longint'($signed(bi)) : longint'(bi);
            p  = x * y;
            r[i*PW +: PW] = p[PW-1:0];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: drive at posedge+1, sample at negedge, return at the next posedge+1.
    task automatic cycle(input logic v, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic s, input logic ordy);
        logic [OW-1:0] e;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        out_ready = ordy;
        @(negedge clk);
        if (prev_stall && !rst) chk("stall_stable", 64'(out_prod), 64'(prev_prod));
        if (out_valid && out_ready && !rst) begin
            chk("out_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_prod", 64'(out_prod), 64'(e));
                got_q.push_back(out_prod);
                n_out++;
            end
        end
        prev_stall = out_valid && !out_ready && !rst;
        prev_prod  = out_prod;
        last_acc   = v && in_ready && !rst;
        if (last_acc) begin
            e = ref_mul(a, b, s);
`ifdef VEC_MUL_MAC_EN
            for (int i = 0; i < LANES; i++) begin
                logic [PW-1:0] pl;
                pl = e[i*PW +: PW];
                if (in_acc && !in_acc_clr) pl = pl + m_acc[i];
                if (in_acc || in_acc_clr) m_acc[i] = pl;
                e[i*PW +: PW] = pl;
            end
`endif
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        repeat (n) begin
            @(negedge clk);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_out_prod", 64'(out_prod), 64'd0);
            @(posedge clk);
        end
        #1;
        rst        = 1'b0;
        prev_stall = 1'b0;
        exp_q.delete();
`ifdef VEC_MUL_MAC_EN
        for (int i = 0; i < LANES; i++) m_acc[i] = '0;
`endif
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 12 && exp_q.size() != 0; k++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // Single beat: not visible one cycle after accept, visible with the given lanes two cycles after.
    task automatic single(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b,
                          input logic s, input logic [OW-1:0] expv);
        cycle(1'b1, a, b, s, 1'b1);
        chk({tag, "_n1_valid"}, 64'(out_valid), 64'd0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        chk({tag, "_n2_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_prod"}, 64'(out_prod), 64'(expv));
        drain({tag, "_drain"});
    endtask

    initial begin
        int            base;
        int            nacc;
        logic [AW-1:0] a_cur, b_cur;
        logic          s_cur;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_signed = 1'b0;
        out_ready = 1'b0;
`ifdef VEC_MUL_MAC_EN
        in_acc     = 1'b0;
        in_acc_clr = 1'b0;
`endif
        do_reset(2);
        out_ready = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk("post_rst_out_prod", 64'(out_prod), 64'd0);

        single("latency", {8'd255, 8'd3, 8'd0, 8'd128}, {8'd255, 8'd5, 8'd77, 8'd2}, 1'b0,
               {16'd65025, 16'd15, 16'd0, 16'd256});
        single("signed_corner", {8'h80, 8'hFF, 8'h7F, 8'h80}, {8'h80, 8'hFF, 8'h80, 8'h01}, 1'b1,
               {16'h4000, 16'h0001, 16'hC080, 16'hFF80});
        single("unsigned_corner", {8'h80, 8'hFF, 8'h7F, 8'h80}, {8'h80, 8'hFF, 8'h80, 8'h01}, 1'b0,
               {16'h4000, 16'hFE01, 16'h3F80, 16'h0080});

        base = n_out;
        for (int k = 0; k < 32; k++) begin
            cycle(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
            chk("stream_in_ready", 64'(in_ready), 64'd1);
        end
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        chk("stream_count", 64'(n_out - base), 64'd32);
        chk("stream_drained", 64'(exp_q.size()), 64'd0);

        base  = n_out;
        nacc  = 0;
        a_cur = $urandom;
        b_cur = $urandom;
        s_cur = 1'($urandom_range(0, 1));
        for (int k = 0; k < 20; k++) begin
            logic ordy;
            ordy = !(k >= 8 && k < 13);
            cycle(1'b1, a_cur, b_cur, s_cur, ordy);
            if (last_acc) begin
                nacc++;
                a_cur = $urandom;
                b_cur = $urandom;
                s_cur = 1'($urandom_range(0, 1));
            end
            if (k >= 8 && k < 13) chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        drain("bp_drained");
        chk("bp_count", 64'(n_out - base), 64'(nacc));

        cycle(1'b1, $urandom, $urandom, 1'b0, 1'b1);
        cycle(1'b1, $urandom, $urandom, 1'b1, 1'b1);
        out_ready = 1'b0;
        do_reset(1);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1);
            chk("mid_rst_no_valid", 64'(out_valid), 64'd0);
        end
        base = n_out;
        cycle(1'b1, $urandom, $urandom, 1'b1, 1'b1);
        drain("mid_rst_drain");
        chk("mid_rst_count", 64'(n_out - base), 64'd1);

`ifdef VEC_MUL_MAC_EN
        got_q.delete();
        in_acc_clr = 1'b1; in_acc = 1'b0;
        cycle(1'b1, {4{8'd3}}, {4{8'd4}}, 1'b0, 1'b1);
        in_acc_clr = 1'b0; in_acc = 1'b1;
        cycle(1'b1, {4{8'd5}}, {4{8'd6}}, 1'b0, 1'b1);
        cycle(1'b1, {4{8'd2}}, {4{8'd2}}, 1'b0, 1'b1);
        in_acc_clr = 1'b1; in_acc = 1'b0;
        cycle(1'b1, {4{8'd255}}, {4{8'd255}}, 1'b0, 1'b1);
        in_acc_clr = 1'b0; in_acc = 1'b1;
        cycle(1'b1, {4{8'd255}}, {4{8'd255}}, 1'b0, 1'b1);
        cycle(1'b1, {4{8'd255}}, {4{8'd255}}, 1'b0, 1'b1);
        in_acc = 1'b0;
        drain("mac_drain");
        chk("mac_count", 64'(got_q.size()), 64'd6);
        chk("mac_clr", 64'(got_q[0]), 64'({4{16'd12}}));
        chk("mac_acc1", 64'(got_q[1]), 64'({4{16'd42}}));
        chk("mac_acc2", 64'(got_q[2]), 64'({4{16'd46}}));
        chk("mac_wrap0", 64'(got_q[3]), 64'({4{16'hFE01}}));
        chk("mac_wrap1", 64'(got_q[4]), 64'({4{16'hFC02}}));
        chk("mac_wrap2", 64'(got_q[5]), 64'({4{16'hFA03}}));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
